// File: rtl/rr_mux_arbiter.sv
// N-channel arbitrating multiplexer with a registered output stage.
// Round-robin (MODE 0) or fixed-priority (MODE 1) selection, valid/ready on all ports.
module rr_mux_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           in_valid,
  input  logic [N*WIDTH-1:0]     in_data,
  output logic [N-1:0]           in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(N)-1:0]   out_sel,
  input  logic                   out_ready
);

  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gsel;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] gdata;
  logic [SEL_W:0]   idx;
  logic             found;
  logic             load;
  logic             xfer;

  // Search starts at ptr and wraps at N explicitly, so a non-power-of-two N never yields an index >= N.
  always_comb begin
    grant = '0;
    gsel  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == 1) begin
        idx = (SEL_W+1)'(k);
      end else begin
        idx = {1'b0, ptr} + (SEL_W+1)'(k);
      end
      if (idx >= (SEL_W+1)'(N)) begin
        idx = idx - (SEL_W+1)'(N);
      end
      if (!found && in_valid[idx[SEL_W-1:0]]) begin
        grant[idx[SEL_W-1:0]] = 1'b1;
        gsel                  = idx[SEL_W-1:0];
        found                 = 1'b1;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = grant & {N{load && rst_n}};
  assign xfer     = |in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_sel   <= gsel;
        if (MODE == 0) begin
          ptr <= (gsel == SEL_W'(N-1)) ? '0 : gsel + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: table-driven round-robin vectors on a 4x8 instance,
// plus hand-written sequences for fixed priority and an N=5 wrap instance.
module tb_rr_mux_arbiter;

  logic clk;
  logic rst_n;

  logic [3:0]  rr_valid;
  logic [31:0] rr_data;
  logic [3:0]  rr_ready;
  logic        rr_ovalid;
  logic [7:0]  rr_odata;
  logic [1:0]  rr_osel;
  logic        rr_oready;

  logic [3:0]  fp_valid;
  logic [31:0] fp_data;
  logic [3:0]  fp_ready;
  logic        fp_ovalid;
  logic [7:0]  fp_odata;
  logic [1:0]  fp_osel;
  logic        fp_oready;

  logic [4:0]  n5_valid;
  logic [39:0] n5_data;
  logic [4:0]  n5_ready;
  logic        n5_ovalid;
  logic [7:0]  n5_odata;
  logic [2:0]  n5_osel;
  logic        n5_oready;

  int total;
  int bad;

  rr_mux_arbiter #(.WIDTH(8), .N(4), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
    .out_valid(rr_ovalid), .out_data(rr_odata), .out_sel(rr_osel), .out_ready(rr_oready)
  );

  rr_mux_arbiter #(.WIDTH(8), .N(4), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(fp_valid), .in_data(fp_data), .in_ready(fp_ready),
    .out_valid(fp_ovalid), .out_data(fp_odata), .out_sel(fp_osel), .out_ready(fp_oready)
  );

  rr_mux_arbiter #(.WIDTH(8), .N(5), .MODE(0)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in_valid(n5_valid), .in_data(n5_data), .in_ready(n5_ready),
    .out_valid(n5_ovalid), .out_data(n5_odata), .out_sel(n5_osel), .out_ready(n5_oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[20];

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic rdy);
    rst_n     = r;
    rr_valid  = v;
    rr_oready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    rr_data  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    fp_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    n5_data  = {8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    fp_valid = '0;
    fp_oready = 1'b1;
    n5_valid = '0;
    n5_oready = 1'b1;

    // Expected values below are the registered state seen before that row's clock edge.
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hAA, 2'd0};
    vecs[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hBB, 2'd1};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hCC, 2'd2};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hDD, 2'd3};
    vecs[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hAA, 2'd0};
    vecs[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hAA, 2'd0};
    vecs[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hAA, 2'd0};
    vecs[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hAA, 2'd0};
    vecs[9]  = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'hBB, 2'd1};
    vecs[10] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hDD, 2'd3};
    vecs[11] = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'hBB, 2'd1};
    vecs[12] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'hDD, 2'd3};
    vecs[13] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hDD, 2'd3};
    vecs[14] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, 8'hDD, 2'd3};
    vecs[15] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hCC, 2'd2};
    vecs[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hCC, 2'd2};
    vecs[17] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0};
    vecs[18] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'hAA, 2'd0};
    vecs[19] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hAA, 2'd0};

    // Reset held for two edges with every channel requesting.
    applyStimulus(1'b0, 4'b1111, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(rr_ready), 32'h0);
    checkOutput("reset out_valid", 32'(rr_ovalid), 32'h0);
    checkOutput("reset out_data", 32'(rr_odata), 32'h0);
    checkOutput("reset out_sel", 32'(rr_osel), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].rdy);
      @(negedge clk);
      checkOutput($sformatf("row%0d in_ready", i), 32'(rr_ready), 32'(vecs[i].exp_ir));
      checkOutput($sformatf("row%0d out_valid", i), 32'(rr_ovalid), 32'(vecs[i].exp_ov));
      checkOutput($sformatf("row%0d out_data", i), 32'(rr_odata), 32'(vecs[i].exp_data));
      checkOutput($sformatf("row%0d out_sel", i), 32'(rr_osel), 32'(vecs[i].exp_sel));
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b1, 4'b0000, 1'b1);

    // Fixed priority: channels 0 and 2 both request, channel 0 must win every cycle.
    fp_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("fp%0d in_ready", k), 32'(fp_ready), 32'h1);
      if (k > 0) begin
        checkOutput($sformatf("fp%0d out_sel", k), 32'(fp_osel), 32'h0);
        checkOutput($sformatf("fp%0d out_data", k), 32'(fp_odata), 32'h11);
      end
      @(posedge clk);
      #1;
    end
    fp_valid = 4'b0100;
    @(negedge clk);
    checkOutput("fp ch2 in_ready", 32'(fp_ready), 32'h4);
    @(posedge clk);
    #1;
    fp_valid = 4'b0000;
    @(negedge clk);
    checkOutput("fp ch2 out_sel", 32'(fp_osel), 32'h2);
    checkOutput("fp ch2 out_data", 32'(fp_odata), 32'h33);
    @(posedge clk);
    #1;

    // N=5 round-robin: sweep past channel 4 and confirm the pointer wraps to 0.
    n5_valid = 5'b11111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("n5 %0d in_ready", k), 32'(n5_ready), 32'(1) << (k % 5));
      if (k > 0) begin
        checkOutput($sformatf("n5 %0d out_sel", k), 32'(n5_osel), 32'((k - 1) % 5));
        checkOutput($sformatf("n5 %0d out_data", k), 32'(n5_odata), 32'(8'hAA + 8'h11 * 8'((k - 1) % 5)));
        checkOutput($sformatf("n5 %0d sel range", k), 32'(n5_osel <= 3'd4), 32'h1);
      end
      @(posedge clk);
      #1;
    end
    n5_valid = 5'b00000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port.
- Generalises the fixed 4:1 single-bit mux. Selection comes from an internal arbiter, round-robin or fixed-priority, instead of an external control input.
- Sits between multiple producers (e.g. memory request sources in the MIPS32 datapath) and one shared consumer.

Parameters:
- WIDTH, 32, data width per channel (1..64).
- N, 4, number of input channels (2..16; need not be a power of two).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_W, derived localparam = ceil(log2(N)), width of the channel index. Not user-settable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept strobe (combinational).
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.

Behaviour:
- Reset (rst_n low at a rising clk edge) clears out_valid, out_data, out_sel and the round-robin pointer ptr to 0. in_ready is 0 while rst_n is low.
- Reset mid-transfer discards the held word; no partial state survives.
- Load enable: load = !out_valid || out_ready. The output register can take a new word when empty or when it drains in the same cycle.
- Grant (combinational, one-hot, at most one bit set):
  - MODE 0: first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - MODE 1: lowest i with in_valid[i]=1.
  - No valid input gives grant = 0.
- in_ready[i] = grant[i] && load && rst_n. in_ready never asserts on a channel whose in_valid is low.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle while out_ready stays high.
- Drain without refill: out_valid && out_ready with no input transfer gives out_valid <= 0. out_data and out_sel keep their last values.
- Stall: while out_valid && !out_ready, out_data and out_sel are held stable and all in_ready are 0.
- Pointer (MODE 0 only): on a transfer from channel g, ptr <= (g == N-1) ? 0 : g+1. Otherwise unchanged. Wrap is explicit so non-power-of-two N never yields an index >= N.
- In MODE 1, ptr stays 0.
- Simultaneous drain and accept in the same cycle is legal: the register is overwritten with the new word and out_valid stays 1.
- Inputs are not required to hold: a producer may drop in_valid before being granted, and arbitration re-evaluates every cycle.
- Once a channel is granted, the word is captured that cycle, so no hold requirement exists after the handshake.
- Fairness (MODE 0): with all N channels continuously valid and out_ready=1, each channel is served exactly once per N consecutive transfers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. After release, first grant is channel 0 (MODE 0).
- Round-robin sweep: N=4, WIDTH=8, MODE 0, in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA}, all valid, out_ready=1 -> out_sel sequence 0,1,2,3,0 with out_data AA, BB, CC, DD, AA on consecutive cycles.
- Backpressure: one word held with out_ready=0 for 3 cycles -> out_data and out_sel stable, in_ready=0000. On out_ready=1, the next grant follows ptr and there is no bubble (out_valid stays 1).
- Sparse requests: only channels 1 and 3 valid, ptr=2 -> channel 3 granted first, then 1, then 3.
- Fixed priority and wrap: MODE 1 with channels 0 and 2 both valid -> channel 0 granted every cycle. Separately, N=5, MODE 0: transfer from channel 4 -> ptr wraps to 0, and out_sel never exceeds 4.
- Mid-operation reset: out_valid=1 and ptr=3, pulse rst_n=0 for one cycle -> out_valid=0 and ptr=0 the next cycle. The held word is never presented again.
